// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory load/store initiator.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEPTH_DEFAULT = 256;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] sword
);

  // Extend a byte or halfword lane to 32 bits, using the lane MSB when signed.
  function automatic logic [31:0] extend(input logic [15:0] lane,
                                         input logic        is_half,
                                         input logic        sext);
    logic fill;
    fill = sext & (is_half ? lane[15] : lane[7]);
    if (is_half)
      extend = {{16{fill}}, lane};
    else
      extend = {{24{fill}}, lane[7:0]};
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane and extend it into the load result.
  always_comb begin
    byte_lane = word[{off, 3'b000} +: 8];
    half_lane = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: ldata = extend({8'h00, byte_lane}, 1'b0, sgn);
      SZ_HALF: ldata = extend(half_lane, 1'b1, sgn);
      default: ldata = word;
    endcase
  end

  // Overwrite only the addressed lane; other lanes pass through bit-identical.
  always_comb begin
    sword = word;
    case (size)
      SZ_BYTE: sword[{off, 3'b000} +: 8]     = sdata[7:0];
      SZ_HALF: sword[{off[1], 4'b0000} +: 16] = sdata[15:0];
      default: sword = sdata;
    endcase
  end

endmodule

// File: rtl/data_mem_master.sv
// Load/store initiator driving a single-port word-addressed data memory.
// Sub-word stores use read-modify-write; bad requests never touch memory.
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nx;
  logic        accept;
  logic        req_bad;
  logic        write_q, sgn_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] ld_val, st_word;

  assign accept = req_valid && (state == IDLE);

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'd3)                                   req_bad = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])               req_bad = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))  req_bad = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))              req_bad = 1'b1;
  end

  mem_lane_align u_align (
    .word  (mem_rdata),
    .off   (addr_q[1:0]),
    .size  (size_q),
    .sgn   (sgn_q),
    .sdata (wdata_q),
    .ldata (ld_val),
    .sword (st_word)
  );

  // State register and error flag; async reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) err_q <= req_bad;
    end
  end

  // Request latch and result register; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      sgn_q   <= req_signed;
      write_q <= req_write;
      wdata_q <= req_wdata;
      rdata_q <= 32'h0;
    end else if (state == READ) begin
      if (write_q) wdata_q <= st_word;
      else         rdata_q <= ld_val;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                    state_nx = RESP;
          else if (!req_write)            state_nx = READ;
          else if (req_size == SZ_WORD)   state_nx = WRITE;
          else                            state_nx = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
        state_nx = write_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wdata = wdata_q;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/data_mem_master.md
# data_mem_master

Load/store initiator that drives the single-port word-addressed data memory (combinational read, write committed on the falling clock edge) from the CPU memory stage. It accepts one byte, halfword or word request at a time and translates byte addresses to word indices. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores run a read-modify-write sequence. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- DEPTH, 256: memory depth in 32-bit words; word indices ≥ DEPTH are out of range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend on loads; ignored on stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned for byte and half.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or out-of-range access; valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write enable.
- mem_addr  out  32  word index, zero-extended req_addr[31:2].
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational memory read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Accept in IDLE: latch addr, size, signed, write and wdata.
  - Error check: size 3, half with addr[0] = 1, word with addr[1:0] ≠ 0, or addr[31:2] ≥ DEPTH → RESP with err = 1.
  - Load → READ.
  - Word store → WRITE.
  - Byte or half store → READ.
- READ: mem_read = 1 and mem_addr = word index for exactly one cycle. At the next edge, capture mem_rdata.
  - Load: extract the lane and extend it into the result register → RESP.
  - Sub-word store: merge the store lane into the captured word → WRITE.
- WRITE: mem_write = 1 for exactly one cycle, with mem_addr and mem_wdata stable for the whole cycle. The memory commits on that cycle's falling edge → RESP.
- RESP: resp_valid = 1 for one cycle → IDLE.
- Lanes are little-endian:
  - Byte k (k = addr[1:0]) occupies bits 8k+7:8k.
  - Half h (h = addr[1]) occupies bits 16h+15:16h.
  - Extension: signed uses the lane MSB; unsigned uses zeros.
- Read-modify-write leaves the other lanes bit-identical.
- mem_read and mem_write are never high together, and never high for error requests.

## Timing
- Reset (async) values: state IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Outputs are registered or decoded from state only. No combinational path from req_* to mem_* or resp_*.
- Cycle counts are measured from accept edge E0:
  - Load: READ in cycle 1, resp_valid in cycle 2, req_ready again in cycle 3.
  - Word store: WRITE in cycle 1, resp_valid in cycle 2.
  - Sub-word store: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- Minimum request spacing is 3 cycles (4 for sub-word stores, 2 for errors). req_valid held high is accepted only while req_ready = 1.
- Reset asserted during WRITE before the falling edge drops mem_write immediately, so no write occurs. Reset asserted after the falling edge leaves the write committed and returns to IDLE. No resp_valid is issued for an aborted request.
- mem_addr and mem_wdata return to 0 in IDLE and RESP.

## Structure
- Package data_mem_pkg holds:
  - the state enum;
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - the DEPTH default.
- One combinational sub-module, mem_lane_align, is natural. It takes word, addr[1:0], size, signed and store data, and returns the extracted/extended load value and the merged store word.
- Top level: FSM, request latch, result register.

## Test plan
- Memory model initialised with word0 = 0x00000007, word1 = 0x00000004. lw at 0x4 → mem_read for one cycle with mem_addr = 1; resp_rdata = 0x00000004 with resp_err = 0, resp_valid in cycle 2.
- sw 0xDEADBEEF at 0x8 → one mem_write cycle with mem_addr = 2 and mem_wdata = 0xDEADBEEF. A following lw at 0x8 returns 0xDEADBEEF.
- sb 0x000000A5 at 0x9 on word 0xDEADBEEF:
  - Response: READ then WRITE with mem_wdata = 0xDEADA5EF.
  - Follow-up loads at 0x9: lb returns 0xFFFFFFA5 and lbu returns 0x000000A5.
- Error cases each give resp_err = 1 in cycle 1, with mem_read and mem_write never asserted:
  - lh at 0x3;
  - lw at 0x2;
  - size 3;
  - sw at 0x400 (word 256).
- Reset pulse during WRITE, before the falling edge, of sw 0x12345678 to 0xC → mem_write falls asynchronously and word 3 is unchanged. After release all outputs are at reset values and req_ready = 1.
- req_valid held high with three back-to-back lw requests → accepts exactly 3 cycles apart and three resp_valid pulses in order.
